// File: rtl/spi_master.sv
// SPI master, mode 0 (CPOL=0, CPHA=0), MSB first: one full-duplex DATA_WIDTH-bit transfer per
// accepted start, SCLK divided from i_clk, SS_n framed with lead, lag and idle gaps.
module spi_master #(
    parameter int DATA_WIDTH = 32,
    parameter int CLK_DIV    = 4,
    parameter int SS_LEAD    = 4,
    parameter int SS_LAG     = 4,
    parameter int SS_IDLE    = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_sclk,
    output logic                  o_ss_n,
    output logic                  o_mosi,
    input  logic                  i_miso
);

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int CNT_MAX = max_of(max_of(CLK_DIV, SS_LEAD), max_of(SS_LAG, SS_IDLE));
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = $clog2(DATA_WIDTH + 1);

    localparam logic [CNT_W-1:0] LEAD_LAST = CNT_W'(SS_LEAD - 1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] LAG_LAST  = CNT_W'(SS_LAG - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(SS_IDLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_XFER,
        ST_TRAIL,
        ST_GAP
    } state_t;

    state_t                state_r;
    state_t                state_next_s;
    logic [CNT_W-1:0]      cnt_r;
    logic [BIT_W-1:0]      bit_cnt_r;
    logic [DATA_WIDTH-1:0] tx_sh_r;
    logic [DATA_WIDTH-1:0] rx_sh_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  sclk_r;
    logic                  ss_n_r;
    logic                  mosi_r;

    logic accept_s;
    logic rise_s;
    logic fall_s;
    logic last_fall_s;
    logic lag_end_s;
    logic idle_end_s;
    logic cnt_wrap_s;

    // Next-state decode; one shared counter times each phase and wraps at that phase's terminal count.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        rise_s       = 1'b0;
        fall_s       = 1'b0;
        last_fall_s  = 1'b0;
        lag_end_s    = 1'b0;
        idle_end_s   = 1'b0;
        cnt_wrap_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_wrap_s = 1'b1;
                if (i_start) begin
                    accept_s     = 1'b1;
                    state_next_s = ST_LEAD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LEAD: begin
                if (cnt_r == LEAD_LAST) begin
                    cnt_wrap_s   = 1'b1;
                    state_next_s = ST_XFER;
                end else begin
                    state_next_s = ST_LEAD;
                end
            end
            ST_XFER: begin
                if (cnt_r == DIV_LAST) begin
                    cnt_wrap_s = 1'b1;
                    if (!sclk_r) begin
                        rise_s       = 1'b1;
                        state_next_s = ST_XFER;
                    end else if (bit_cnt_r == BIT_LAST) begin
                        fall_s       = 1'b1;
                        last_fall_s  = 1'b1;
                        state_next_s = ST_TRAIL;
                    end else begin
                        fall_s       = 1'b1;
                        state_next_s = ST_XFER;
                    end
                end else begin
                    state_next_s = ST_XFER;
                end
            end
            ST_TRAIL: begin
                if (cnt_r == LAG_LAST) begin
                    cnt_wrap_s   = 1'b1;
                    lag_end_s    = 1'b1;
                    state_next_s = ST_GAP;
                end else begin
                    state_next_s = ST_TRAIL;
                end
            end
            ST_GAP: begin
                if (cnt_r == IDLE_LAST) begin
                    cnt_wrap_s   = 1'b1;
                    idle_end_s   = 1'b1;
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_GAP;
                end
            end
            default: begin
                cnt_wrap_s   = 1'b1;
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath: shifters, SPI pins and status flags, all driven straight from flops.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_r     <= {CNT_W{1'b0}};
            bit_cnt_r <= {BIT_W{1'b0}};
            tx_sh_r   <= {DATA_WIDTH{1'b0}};
            rx_sh_r   <= {DATA_WIDTH{1'b0}};
            data_r    <= {DATA_WIDTH{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            sclk_r    <= 1'b0;
            ss_n_r    <= 1'b1;
            mosi_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            cnt_r  <= cnt_wrap_s ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
            if (accept_s) begin
                tx_sh_r   <= i_data;
                rx_sh_r   <= {DATA_WIDTH{1'b0}};
                bit_cnt_r <= {BIT_W{1'b0}};
                mosi_r    <= i_data[DATA_WIDTH-1];
                ss_n_r    <= 1'b0;
                busy_r    <= 1'b1;
            end
            // MISO is captured on the very edge that raises SCLK.
            if (rise_s) begin
                sclk_r  <= 1'b1;
                rx_sh_r <= {rx_sh_r[DATA_WIDTH-2:0], i_miso};
            end
            if (fall_s) begin
                sclk_r    <= 1'b0;
                bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                tx_sh_r   <= {tx_sh_r[DATA_WIDTH-2:0], 1'b0};
                mosi_r    <= last_fall_s ? 1'b0 : tx_sh_r[DATA_WIDTH-2];
            end
            if (lag_end_s) begin
                ss_n_r <= 1'b1;
                data_r <= rx_sh_r;
                done_r <= 1'b1;
            end
            if (idle_end_s) begin
                busy_r <= 1'b0;
            end
        end
    end

    assign o_data = data_r;
    assign o_busy = busy_r;
    assign o_done = done_r;
    assign o_sclk = sclk_r;
    assign o_ss_n = ss_n_r;
    assign o_mosi = mosi_r;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: two instances (default timing and the fast CLK_DIV=2/1/1/1 set), a
// per-cycle pin-level reference derived from the transfer timing formulas, and a slave model.
module tb_spi_master;

    localparam int W  = 32;
    localparam int NI = 2;

    typedef struct {
        logic [W-1:0] tx;
        logic [W-1:0] rx;
        int           e0;
    } rec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start [NI] = '{1'b0, 1'b0};
    logic [W-1:0] din   [NI] = '{32'h0, 32'h0};
    logic [W-1:0] dout  [NI];
    logic         busy  [NI];
    logic         done  [NI];
    logic         sclk  [NI];
    logic         ss_n  [NI];
    logic         mosi  [NI];
    logic         miso  [NI];

    logic         loop0 = 1'b1;
    logic [W-1:0] sl_word = 32'h0;
    logic [W-1:0] sl_tx;
    logic [W-1:0] sl_rx;
    logic         sl_miso;
    logic         sclk0;
    logic         ss0_n;

    int           cyc = 0;
    int           checks = 0;
    int           failures = 0;
    int           stim_timeouts = 0;
    logic         stim_end = 1'b0;
    rec_t         exp_q [NI][$];
    logic [W-1:0] exp_data [NI] = '{32'h0, 32'h0};

    function automatic int p_cd(input int g);   return (g == 0) ? 4 : 2; endfunction
    function automatic int p_lead(input int g); return (g == 0) ? 4 : 1; endfunction
    function automatic int p_lag(input int g);  return (g == 0) ? 4 : 1; endfunction
    function automatic int p_idle(input int g); return (g == 0) ? 4 : 1; endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        spi_master #(
            .DATA_WIDTH(W),
            .CLK_DIV   ((g == 0) ? 4 : 2),
            .SS_LEAD   ((g == 0) ? 4 : 1),
            .SS_LAG    ((g == 0) ? 4 : 1),
            .SS_IDLE   ((g == 0) ? 4 : 1)
        ) u_dut (
            .i_clk  (clk),
            .i_rst  (rst),
            .i_start(start[g]),
            .i_data (din[g]),
            .o_data (dout[g]),
            .o_busy (busy[g]),
            .o_done (done[g]),
            .o_sclk (sclk[g]),
            .o_ss_n (ss_n[g]),
            .o_mosi (mosi[g]),
            .i_miso (miso[g])
        );
    end

    assign miso[0] = loop0 ? mosi[0] : sl_miso;
    assign miso[1] = mosi[1];
    assign sclk0   = sclk[0];
    assign ss0_n   = ss_n[0];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Mode-0 slave: presents MSB when selected, shifts out on SCLK falls, samples MOSI on rises.
    always @(negedge ss0_n) begin
        sl_tx   <= sl_word;
        sl_miso <= sl_word[W-1];
        sl_rx   <= 32'h0;
    end
    always @(posedge sclk0) if (!ss0_n) sl_rx <= {sl_rx[W-2:0], mosi[0]};
    always @(negedge sclk0) begin
        if (!ss0_n) begin
            sl_tx   <= {sl_tx[W-2:0], 1'b0};
            sl_miso <= sl_tx[W-2];
        end
    end

    task automatic cmp(input string name, input int g, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s dut%0d cyc=%0d actual=%h expected=%h", name, g, cyc, act, exp);
        end
    endtask

    // Expected pins for one instance at the current cycle, from the transfer at the queue head.
    task automatic check_inst(input int g);
        int         lead, cd, lag, idle, tn, t, k;
        logic [4:0] exp_v;
        logic       active;
        rec_t       r;
        lead   = p_lead(g);
        cd     = p_cd(g);
        lag    = p_lag(g);
        idle   = p_idle(g);
        tn     = lead + 2 * W * cd + lag;
        exp_v  = 5'b00010;
        active = 1'b0;
        t      = 0;
        if (exp_q[g].size() > 0) begin
            r = exp_q[g][0];
            if (cyc >= r.e0) active = 1'b1;
        end
        if (active) begin
            t        = cyc - r.e0;
            exp_v[4] = (t < tn + idle);
            exp_v[3] = (t == tn);
            exp_v[2] = (t >= lead + cd && t < lead + 2 * W * cd) ? (((t - lead) / cd) % 2 == 1) : 1'b0;
            exp_v[1] = (t >= tn);
            if (t < lead + 2 * W * cd) begin
                k        = (t < lead) ? 0 : (t - lead) / (2 * cd);
                exp_v[0] = r.tx[W-1-k];
            end
            if (t == tn) begin
                exp_data[g] = r.rx;
                if (g == 0 && !loop0) cmp("slave_rx", g, sl_rx, r.tx);
            end
        end
        cmp("pins_busy_done_sclk_ssn_mosi", g, 32'({busy[g], done[g], sclk[g], ss_n[g], mosi[g]}), 32'(exp_v));
        cmp("o_data", g, dout[g], exp_data[g]);
        if (active && t >= tn + idle) void'(exp_q[g].pop_front());
    endtask

    // Monitor: runs 1 time unit after every active edge.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            for (int g = 0; g < NI; g++) begin
                if (exp_q[g].size() > 0 && exp_q[g][0].e0 <= cyc) void'(exp_q[g].pop_front());
                exp_data[g] = 32'h0;
            end
        end
        for (int g = 0; g < NI; g++) check_inst(g);
        if (stim_end) begin
            cmp("stimulus_wait_timeouts", 0, 32'(stim_timeouts), 32'h0);
            for (int g = 0; g < NI; g++) cmp("transfers_left", g, 32'(exp_q[g].size()), 32'h0);
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end else if (cyc > 60000) begin
            checks++;
            failures++;
            $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Called at a negedge; the following edge becomes the accept edge.
    task automatic issue(input int g, input logic [W-1:0] tx, input logic [W-1:0] rx, input bit hold,
                         output int e0);
        int   n;
        rec_t r;
        n = 0;
        while (busy[g] !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (busy[g] !== 1'b0) stim_timeouts++;
        start[g] = 1'b1;
        din[g]   = tx;
        e0       = cyc + 1;
        r.tx = tx;
        r.rx = rx;
        r.e0 = e0;
        exp_q[g].push_back(r);
        @(negedge clk);
        if (!hold) start[g] = 1'b0;
        din[g] = $urandom();
    endtask

    task automatic wait_idle(input int g);
        int n;
        n = 0;
        @(negedge clk);
        while ((exp_q[g].size() != 0 || busy[g] !== 1'b0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) stim_timeouts++;
    endtask

    // Start held high: the second accept must land exactly one cycle after busy drops.
    task automatic held_pair(input int g, input logic [W-1:0] w1, input logic [W-1:0] w2);
        int   e0a, e0b;
        rec_t r;
        issue(g, w1, w1, 1'b1, e0a);
        din[g] = w2;
        e0b  = e0a + p_lead(g) + 2 * W * p_cd(g) + p_lag(g) + p_idle(g) + 1;
        r.tx = w2;
        r.rx = w2;
        r.e0 = e0b;
        exp_q[g].push_back(r);
        wait_until(e0b);
        start[g] = 1'b0;
        wait_idle(g);
    endtask

    initial begin
        int           e0;
        logic [W-1:0] w;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        loop0 = 1'b1;
        issue(0, 32'hA5C3_0F96, 32'hA5C3_0F96, 1'b0, e0);
        wait_idle(0);

        loop0   = 1'b0;
        sl_word = 32'hDEAD_BEEF;
        issue(0, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0, e0);
        wait_idle(0);

        loop0 = 1'b1;
        issue(0, 32'h0000_0000, 32'h0000_0000, 1'b0, e0);
        wait_idle(0);
        issue(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, e0);
        wait_idle(0);

        w = $urandom();
        issue(0, w, w, 1'b0, e0);
        wait_until(e0 + 9);
        start[0] = 1'b1;
        din[0]   = $urandom();
        @(negedge clk);
        start[0] = 1'b0;
        wait_until(e0 + 199);
        start[0] = 1'b1;
        din[0]   = $urandom();
        @(negedge clk);
        start[0] = 1'b0;
        wait_idle(0);

        held_pair(0, $urandom(), $urandom());

        w = $urandom();
        issue(0, w, w, 1'b0, e0);
        wait_until(e0 + 99);
        rst = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        loop0   = 1'b0;
        sl_word = $urandom();
        issue(0, 32'h5A5A_C3C3, sl_word, 1'b0, e0);
        wait_idle(0);

        for (int i = 0; i < 6; i++) begin
            loop0   = 1'($urandom_range(0, 1));
            sl_word = $urandom();
            w       = $urandom();
            issue(0, w, loop0 ? w : sl_word, 1'b0, e0);
            wait_idle(0);
        end

        loop0 = 1'b1;
        issue(1, 32'hA5C3_0F96, 32'hA5C3_0F96, 1'b0, e0);
        wait_idle(1);
        for (int i = 0; i < 5; i++) begin
            w = $urandom();
            issue(1, w, w, 1'b0, e0);
            wait_idle(1);
        end
        held_pair(1, $urandom(), $urandom());

        stim_end = 1'b1;
    end

endmodule

// File: doc/spi_master.md
# spi_master

Single-clock SPI master (mode 0: CPOL=0, CPHA=0, MSB first) that drives the SPI slave peripheral from the processor side. It runs one full-duplex DATA_WIDTH-bit transfer per start request. It generates SCLK by dividing i_clk and frames each transfer with SS_n using programmable lead, lag and idle gaps. It sits behind the bus-register wrapper, which supplies the TX word and collects the RX word.

## Interface
- DATA_WIDTH, 32: transfer length in bits.
- CLK_DIV, 4: i_clk cycles per SCLK half-period; must be ≥2.
- SS_LEAD, 4: cycles from SS_n falling to the first SCLK rise, minus CLK_DIV; must be ≥1.
- SS_LAG, 4: cycles from the last SCLK fall to SS_n rising; must be ≥1.
- SS_IDLE, 4: minimum cycles SS_n stays high before busy drops; must be ≥1.

Ports:
- i_clk, in, 1: system clock; all logic on posedge.
- i_rst, in, 1: synchronous, active-high reset.
- i_start, in, 1: transfer request; sampled only while o_busy=0.
- i_data, in, DATA_WIDTH: TX word, captured on the accepting edge.
- o_data, out, DATA_WIDTH: RX word; updated only at transfer completion.
- o_busy, out, 1: high from the accept edge until the gap ends.
- o_done, out, 1: one-cycle pulse when o_data is updated.
- o_sclk, out, 1: SPI clock.
- o_ss_n, out, 1: active-low slave select.
- o_mosi, out, 1: serial data to the slave.
- i_miso, in, 1: serial data from the slave.

## Operation
- Reset values: o_data=0, o_busy=0, o_done=0, o_sclk=0, o_ss_n=1, o_mosi=0. FSM goes to IDLE; all counters clear.
- FSM states: IDLE → LEAD → XFER → TRAIL → GAP → IDLE.
- IDLE, on i_start=1 at edge E0:
  - tx_sh ← i_data; o_mosi ← i_data[DATA_WIDTH-1].
  - o_ss_n ← 0; o_busy ← 1; go to LEAD.
- LEAD: hold o_sclk=0 for SS_LEAD cycles, then go to XFER.
- XFER: a half-period counter runs 0..CLK_DIV-1, and o_sclk toggles at the terminal count.
  - Rising toggle: rx_sh ← {rx_sh[DATA_WIDTH-2:0], i_miso}. i_miso is sampled on the same edge that drives o_sclk high.
  - Falling toggle: bit counter increments, tx_sh shifts left by one, o_mosi ← next tx bit. On the DATA_WIDTH-th fall, o_mosi ← 0 and the FSM goes to TRAIL.
- TRAIL: hold o_sclk=0 for SS_LAG cycles. On the final edge:
  - o_ss_n ← 1, o_data ← rx_sh, o_done ← 1.
  - Go to GAP.
- GAP: o_done returns to 0 after one cycle. After SS_IDLE cycles, o_busy ← 0 and the FSM goes to IDLE.
- i_start while o_busy=1 is ignored, not queued. i_data is sampled only on the accept edge.
- i_start held high continuously gives back-to-back transfers. Each is separated by SS_IDLE cycles of SS_n high plus the one IDLE cycle in which the new request is accepted.
- i_rst asserted mid-transfer: every output takes its reset value on the next edge. The partial RX word is discarded, o_data is cleared, and no o_done pulse is issued.
- System constraint: SS_LEAD+CLK_DIV and SS_IDLE must each cover at least 2 slave-clock periods. The slave detects SS_n edges and loads or unloads its buffers in its own clock domain.

## Timing
- Let W=DATA_WIDTH and E0 be the accept edge.
- First SCLK rise: edge E0+SS_LEAD+CLK_DIV.
- Bit k (k=0 is the MSB):
  - Rise at E0+SS_LEAD+(2k+1)·CLK_DIV.
  - Fall at E0+SS_LEAD+(2k+2)·CLK_DIV.
- Last fall: E0+SS_LEAD+2W·CLK_DIV.
- Completion edge N = E0+SS_LEAD+2W·CLK_DIV+SS_LAG. On this edge o_ss_n rises and o_data becomes valid. o_done is high for exactly the cycle after N.
- o_busy falls at edge N+SS_IDLE. A new request is accepted no earlier than edge N+SS_IDLE+1.
- Defaults (W=32, all other parameters 4): N=E0+264; o_busy falls at E0+268.
- SCLK duty cycle is 50%: high and low phases are each exactly CLK_DIV cycles. o_sclk is glitch-free because it is driven directly from a flop.
- o_mosi changes only on falling toggles or the accept edge, so it is stable for CLK_DIV cycles around every rise.

## Test plan
- Loopback (o_mosi tied to i_miso), defaults, i_data=32'hA5C3_0F96:
  - o_data=32'hA5C3_0F96 and o_done pulses at E0+265.
  - Exactly 32 SCLK rises occur while o_ss_n=0.
- Against the SPI slave model with its TX word=32'hDEAD_BEEF and master i_data=32'h1234_5678: master o_data=32'hDEAD_BEEF and slave RX=32'h1234_5678.
- CLK_DIV=2, SS_LEAD=1, SS_LAG=1, SS_IDLE=1: SCLK period is 4 cycles and N=E0+130. Checker verifies high/low phases of exactly 2 cycles.
- i_start pulsed at E0+10 and E0+200 during a transfer: both ignored. o_busy stays high and only one o_done occurs. i_start held high gives the next accept exactly at N+SS_IDLE+1.
- i_rst asserted at E0+100 for one cycle:
  - Next cycle: o_ss_n=1, o_sclk=0, o_mosi=0, o_busy=0, o_data=0, o_done never pulses.
  - A subsequent transfer completes correctly.
- All-zeros and all-ones words (32'h0, 32'hFFFF_FFFF) in loopback return unchanged. o_mosi=0 in IDLE and TRAIL.
